i2c_mpu_responder: RTL and testbench

// - I2C target (responder) emulating the MPU6050 register subset that the design's MPU6050 I2C master reads.
// - Lets the tamagotchi sensor path run in simulation, and on boards without the sensor, using the same SDA/SCL pins.
// - Accel samples enter from fabric (tb or pattern gen).
// - Register writes made by the master are echoed out as a strobe.

---
 rtl/i2c_mpu_responder.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_i2c_mpu_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mpu_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_mpu_responder                                             |
// | Brief    : I2C target emulating the MPU6050 registers the master reads.  |
// |            Optional clock stretching with macro I2C_CLK_STRETCH_EN.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_mpu_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter logic [7:0] WHO_AM_I    = 8'h68,
    parameter int         SYNC_STAGES = 2,
    parameter int         STRETCH_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        scl_oe,
    input  logic [15:0] accel_x_i,
    input  logic [15:0] accel_y_i,
    input  logic [15:0] accel_z_i,
    output logic        busy,
    output logic        wr_strb,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data
);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_ADDR      = 4'd1;
    localparam logic [3:0] c_ADDR_ACK  = 4'd2;
    localparam logic [3:0] c_PTR       = 4'd3;
    localparam logic [3:0] c_PTR_ACK   = 4'd4;
    localparam logic [3:0] c_WDATA     = 4'd5;
    localparam logic [3:0] c_WDATA_ACK = 4'd6;
    localparam logic [3:0] c_RDATA     = 4'd7;
    localparam logic [3:0] c_RD_MACK   = 4'd8;
    localparam logic [3:0] c_IGNORE    = 4'd9;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;

    logic [3:0]  r_state;
    logic [3:0]  w_state_nxt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_tx;
    logic [7:0]  r_ptr;
    logic [7:0]  r_pwr;
    logic [15:0] r_sh_x;
    logic [15:0] r_sh_y;
    logic [15:0] r_sh_z;
    logic        r_mack_n;
    logic        r_busy;
    logic        r_sda_oe;
    logic        r_wr_strb;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;

    logic        w_sda_oe_nxt;
    logic [7:0]  w_rd_byte;
    logic [7:0]  w_rx_byte;
    logic        w_addr_match;
    logic        w_rise8;
    logic        w_fall8;
    logic        w_fall9;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign w_rx_byte    = {r_shift[6:0], w_sda};
    assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
    assign w_rise8      = w_scl_rise && (r_bit_cnt == 4'd7);
    assign w_fall8      = w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_fall9      = w_scl_fall && (r_bit_cnt == 4'd9);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; bus conditions override every state
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = c_IDLE;
        end else if (w_start) begin
            w_state_nxt = c_ADDR;
        end else begin
            case (r_state)
                c_ADDR:      if (w_fall8) w_state_nxt = w_addr_match ? c_ADDR_ACK : c_IGNORE;
                c_ADDR_ACK:  if (w_fall9) w_state_nxt = r_shift[0] ? c_RDATA : c_PTR;
                c_PTR:       if (w_fall8) w_state_nxt = c_PTR_ACK;
                c_PTR_ACK:   if (w_fall9) w_state_nxt = c_WDATA;
                c_WDATA:     if (w_fall8) w_state_nxt = c_WDATA_ACK;
                c_WDATA_ACK: if (w_fall9) w_state_nxt = c_WDATA;
                c_RDATA:     if (w_fall8) w_state_nxt = c_RD_MACK;
                c_RD_MACK:   if (w_fall9) w_state_nxt = r_mack_n ? c_IGNORE : c_RDATA;
                default:     w_state_nxt = r_state;
            endcase
        end
    end

    // Output logic: read mux and the next SDA drive value
    always_comb begin
        case (r_ptr)
            8'h3B:   w_rd_byte = r_sh_x[15:8];
            8'h3C:   w_rd_byte = r_sh_x[7:0];
            8'h3D:   w_rd_byte = r_sh_y[15:8];
            8'h3E:   w_rd_byte = r_sh_y[7:0];
            8'h3F:   w_rd_byte = r_sh_z[15:8];
            8'h40:   w_rd_byte = r_sh_z[7:0];
            8'h6B:   w_rd_byte = r_pwr;
            8'h75:   w_rd_byte = WHO_AM_I;
            default: w_rd_byte = 8'h00;
        endcase

        w_sda_oe_nxt = r_sda_oe;
        if (w_stop || w_start) begin
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                c_ADDR:      if (w_fall8) w_sda_oe_nxt = w_addr_match;
                c_PTR,
                c_WDATA:     if (w_fall8) w_sda_oe_nxt = 1'b1;
                c_ADDR_ACK:  if (w_fall9) w_sda_oe_nxt = r_shift[0] & ~w_rd_byte[7];
                c_PTR_ACK,
                c_WDATA_ACK: if (w_fall9) w_sda_oe_nxt = 1'b0;
                c_RDATA: begin
                    if (w_fall8) begin
                        w_sda_oe_nxt = 1'b0;
                    end else if (w_scl_fall && (r_bit_cnt != 4'd0) && (r_bit_cnt < 4'd8)) begin
                        w_sda_oe_nxt = ~r_tx[6];
                    end
                end
                c_RD_MACK:   if (w_fall9) w_sda_oe_nxt = ~r_mack_n & ~w_rd_byte[7];
                default:     w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    // Datapath: synchronizers, bit counter, pointer, registers, outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_tx       <= 8'h00;
            r_ptr      <= 8'h00;
            r_pwr      <= 8'h40;
            r_sh_x     <= 16'h0000;
            r_sh_y     <= 16'h0000;
            r_sh_z     <= 16'h0000;
            r_mack_n   <= 1'b1;
            r_busy     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_strb  <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 8'h00;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_sda_oe   <= w_sda_oe_nxt;
            r_wr_strb  <= 1'b0;

            if (w_start || w_stop || w_fall9) begin
                r_bit_cnt <= 4'd0;
            end else if (w_scl_rise && (r_bit_cnt != 4'd9)) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_stop) begin
                r_busy <= 1'b0;
            end else if (!w_start) begin
                case (r_state)
                    c_ADDR: begin
                        if (w_scl_rise && (r_bit_cnt < 4'd8)) r_shift <= w_rx_byte;
                        if (w_fall8 && w_addr_match) begin
                            r_busy <= 1'b1;
                            // Snapshot all axes so a burst read sees one coherent sample
                            if (r_shift[0]) begin
                                r_sh_x <= accel_x_i;
                                r_sh_y <= accel_y_i;
                                r_sh_z <= accel_z_i;
                            end
                        end
                    end
                    c_PTR: begin
                        if (w_scl_rise && (r_bit_cnt < 4'd8)) r_shift <= w_rx_byte;
                        if (w_rise8) r_ptr <= w_rx_byte;
                    end
                    c_WDATA: begin
                        if (w_scl_rise && (r_bit_cnt < 4'd8)) r_shift <= w_rx_byte;
                        if (w_rise8) begin
                            r_wr_strb <= 1'b1;
                            r_wr_addr <= r_ptr;
                            r_wr_data <= w_rx_byte;
                            r_ptr     <= r_ptr + 8'd1;
                            if (r_ptr == 8'h6B) r_pwr <= w_rx_byte;
                        end
                    end
                    c_ADDR_ACK: begin
                        if (w_fall9 && r_shift[0]) r_tx <= w_rd_byte;
                    end
                    c_RDATA: begin
                        if (w_fall8) begin
                            r_ptr <= r_ptr + 8'd1;
                        end else if (w_scl_fall && (r_bit_cnt != 4'd0)) begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                    c_RD_MACK: begin
                        if (w_scl_rise) r_mack_n <= w_sda;
                        if (w_fall9 && !r_mack_n) r_tx <= w_rd_byte;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign wr_strb = r_wr_strb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

`ifdef I2C_CLK_STRETCH_EN
    localparam int c_STR_W = $clog2(STRETCH_CYC + 1);

    logic               w_stretch_go;
    logic               r_scl_oe;
    logic [c_STR_W-1:0] r_str_cnt;

    // Stretch only after ACK bits that lead to another data byte
    assign w_stretch_go = w_fall9 &&
                          ((r_state == c_ADDR_ACK) || (r_state == c_PTR_ACK) ||
                           (r_state == c_WDATA_ACK) || ((r_state == c_RD_MACK) && !r_mack_n));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_oe  <= 1'b0;
            r_str_cnt <= '0;
        end else if (w_start || w_stop) begin
            r_scl_oe  <= 1'b0;
            r_str_cnt <= '0;
        end else if (w_stretch_go) begin
            r_scl_oe  <= 1'b1;
            r_str_cnt <= c_STR_W'(STRETCH_CYC - 1);
        end else if (r_scl_oe) begin
            if (r_str_cnt == '0) begin
                r_scl_oe <= 1'b0;
            end else begin
                r_str_cnt <= r_str_cnt - 1'b1;
            end
        end
    end

    assign scl_oe = r_scl_oe;
`else
    assign scl_oe = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_mpu_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i2c_mpu_responder                                          |
// | Brief    : Directed bus-level bench acting as the I2C master.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_i2c_mpu_responder;

    localparam int Q = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        sda_oe;
    logic        scl_oe;
    logic [15:0] ax;
    logic [15:0] ay;
    logic [15:0] az;
    logic        busy;
    logic        wr_strb;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        scl_bus;
    logic        sda_bus;

    assign scl_bus = scl_m & ~scl_oe;
    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_mpu_responder dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_bus),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .scl_oe    (scl_oe),
        .accel_x_i (ax),
        .accel_y_i (ay),
        .accel_z_i (az),
        .busy      (busy),
        .wr_strb   (wr_strb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    int checks = 0;
    int passed = 0;

    int         strb_cnt  = 0;
    int         oe_cycles = 0;
    int         oe_viol   = 0;
    logic [7:0] last_wa   = 8'h00;
    logic [7:0] last_wd   = 8'h00;
    logic       prev_scl  = 1'b1;
    logic       prev_oe   = 1'b0;
    logic       prev_rst  = 1'b0;

    // Bus monitor: strobes, SDA drive activity, SDA changes during SCL high
    always @(posedge clk) begin
        if (wr_strb) begin
            strb_cnt <= strb_cnt + 1;
            last_wa  <= wr_addr;
            last_wd  <= wr_data;
        end
        if (sda_oe) oe_cycles <= oe_cycles + 1;
        if (rst && prev_rst && scl_bus && prev_scl && (sda_oe != prev_oe)) oe_viol <= oe_viol + 1;
        prev_scl <= scl_bus;
        prev_oe  <= sda_oe;
        prev_rst <= rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_scl_high();
        int n;
        n = 0;
        while (!scl_bus && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (!scl_bus) chk("scl_release_timeout", {31'd0, scl_bus}, 32'd1);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        wait_scl_high();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        scl_m = 1'b0;
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        wait_scl_high();
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;
        #Q scl_m = 1'b1;
        wait_scl_high();
        #Q s = sda_bus;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    // START, write pointer, repeated START, address for read
    task automatic point_and_read(input logic [7:0] p, input string tag);
        logic ack;
        i2c_start();
        write_byte(8'hD0, ack);
        chk({tag, "_addr_w_ack"}, {31'd0, ack}, 32'd1);
        write_byte(p, ack);
        chk({tag, "_ptr_ack"}, {31'd0, ack}, 32'd1);
        i2c_start();
        write_byte(8'hD1, ack);
        chk({tag, "_addr_r_ack"}, {31'd0, ack}, 32'd1);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         snap_strb;
        int         snap_oe;

        rst   = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        ax    = 16'h1234;
        ay    = 16'h5678;
        az    = 16'h9ABC;
        repeat (5) @(negedge clk);
        chk("rst_sda_oe",  {31'd0, sda_oe},  32'd0);
        chk("rst_scl_oe",  {31'd0, scl_oe},  32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_wr_strb", {31'd0, wr_strb}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_state",   {28'd0, dut.r_state}, 32'd0);
        @(negedge clk) rst = 1'b1;
        #Q;

        // Write PWR_MGMT_1 = 0x00
        i2c_start();
        write_byte(8'hD0, ack);
        chk("wr_addr_ack", {31'd0, ack}, 32'd1);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        snap_strb = strb_cnt;
        write_byte(8'h6B, ack);
        chk("wr_ptr_ack", {31'd0, ack}, 32'd1);
        chk("wr_ptr_no_strobe", strb_cnt, snap_strb);
        write_byte(8'h00, ack);
        chk("wr_data_ack", {31'd0, ack}, 32'd1);
        chk("wr_strobe_count", strb_cnt, snap_strb + 1);
        chk("wr_strobe_addr", {24'd0, last_wa}, 32'h6B);
        chk("wr_strobe_data", {24'd0, last_wd}, 32'h00);
        i2c_stop();
        chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);

        point_and_read(8'h6B, "pwr");
        read_byte(1'b1, d);
        chk("pwr_readback", {24'd0, d}, 32'h00);
        i2c_stop();

        // WHO_AM_I
        point_and_read(8'h75, "who");
        read_byte(1'b1, d);
        chk("who_am_i", {24'd0, d}, 32'h68);
        chk("who_busy_before_stop", {31'd0, busy}, 32'd1);
        i2c_stop();
        chk("who_busy_after_stop", {31'd0, busy}, 32'd0);

        // Six-byte accel burst with inputs changing mid-burst
        point_and_read(8'h3B, "acc");
        read_byte(1'b0, d);
        chk("acc_x_h", {24'd0, d}, 32'h12);
        ax = 16'hFFFF;
        ay = 16'hEEEE;
        az = 16'hDDDD;
        read_byte(1'b0, d);
        chk("acc_x_l", {24'd0, d}, 32'h34);
        read_byte(1'b0, d);
        chk("acc_y_h", {24'd0, d}, 32'h56);
        read_byte(1'b0, d);
        chk("acc_y_l", {24'd0, d}, 32'h78);
        read_byte(1'b0, d);
        chk("acc_z_h", {24'd0, d}, 32'h9A);
        read_byte(1'b1, d);
        chk("acc_z_l", {24'd0, d}, 32'hBC);
        i2c_stop();
        chk("acc_ptr_end", {24'd0, dut.r_ptr}, 32'h41);

        // Foreign address 0x69
        snap_strb = strb_cnt;
        snap_oe   = oe_cycles;
        i2c_start();
        write_byte(8'hD2, ack);
        chk("nomatch_no_ack", {31'd0, ack}, 32'd0);
        chk("nomatch_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h6B, ack);
        chk("nomatch_byte_no_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        chk("nomatch_sda_oe_idle", oe_cycles, snap_oe);
        chk("nomatch_no_strobe", strb_cnt, snap_strb);

        // Pointer wrap 0xFF -> 0x00 -> 0x01
        point_and_read(8'hFF, "wrap");
        read_byte(1'b0, d);
        chk("wrap_byte0", {24'd0, d}, 32'h00);
        read_byte(1'b1, d);
        chk("wrap_byte1", {24'd0, d}, 32'h00);
        i2c_stop();
        chk("wrap_ptr", {24'd0, dut.r_ptr}, 32'h01);

        // Reset asserted while driving the first read bit of WHO_AM_I (bit7 = 0)
        point_and_read(8'h75, "mid");
        chk("mid_drive_bit7", {31'd0, sda_oe}, 32'd1);
        scl_m = 1'b1;
        wait_scl_high();
        #(Q / 2) rst = 1'b0;
        #20;
        chk("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_state", {28'd0, dut.r_state}, 32'd0);
        sda_m = 1'b1;
        #Q;
        @(negedge clk) rst = 1'b1;
        #Q;
        point_and_read(8'h6B, "post");
        read_byte(1'b1, d);
        chk("post_pwr_default", {24'd0, d}, 32'h40);
        i2c_stop();

        clk_bit(1'b1, s);
        chk("sda_oe_stable_scl_high", oe_viol, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
